rx_bl_commit_buf: RTL and testbench

//  Staging buffer downstream of the UART block receiver. Captures data bytes (in_ce/in_dat/in_adr)
//  of the current block, holds them until block end. Good CRC (blk_ok): replays bytes to the

---
 rtl/rxb_pkg.sv | 25 ++
 rtl/rxb_sdp_ram.sv | 44 ++++
 rtl/rx_bl_commit_buf.sv | 239 +++++++++++++++++++++++
 tb/tb_rx_bl_commit_buf.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rxb_pkg.sv
// Shared definitions for the block-receive commit buffer.
//   - Default geometry (staging depth, address width, data width).
//   - Counter width able to hold the value DEPTH itself.
//   - FSM state type.
//   - Helper for the low-byte address wrap used when replaying a block.
package rxb_pkg;

    localparam int unsigned DEF_DEPTH = 256;
    localparam int unsigned DEF_AW    = 16;
    localparam int unsigned DEF_DW    = 8;
    localparam int unsigned DEF_CNT_W = $clog2(DEF_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } rxb_state_e;

    // The receiver wraps the low address byte with no carry into the high byte.
    // The replay path must follow the same rule.
    function automatic logic [7:0] rxb_lo_add(input logic [7:0] base_lo, input logic [7:0] idx);
        return base_lo + idx;
    endfunction

endpackage

// File: rtl/rxb_sdp_ram.sv
// Simple dual-port staging RAM: DEPTH x DW.
//   - One write port.
//   - One read port with a registered output.
// The read register only loads when i_re is high. The output therefore holds its value while the
// consumer is stalled.
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write index
//   i_wdata  write data
//   i_re     read enable (loads o_rdata on the next edge)
//   i_raddr  read index
//   o_rdata  registered read data
module rxb_sdp_ram
    import rxb_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned IW    = $clog2(DEF_DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [IW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [IW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/rx_bl_commit_buf.sv
// Staging buffer between the UART block receiver and target memory.
//   - Collects the data bytes of the current block.
//   - On a good CRC, replays the bytes to memory over a valid/ready port.
//   - On a bad CRC or a lost byte, discards the whole block.
// Reset is synchronous, active-low.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_ce/in_dat/in_adr         byte strobe, data and target address from the receiver
//   blk_end, blk_ok             end-of-block pulse; CRC good flag, qualified by blk_end
//   mem_we/mem_adr/mem_dat      write request; held stable until mem_rdy
//   mem_rdy                     target accepts (transfer = mem_we & mem_rdy)
//   bl_commit, bl_drop          one-clock result pulses
//   ovf                         sticky lost-byte flag, cleared by reset only
//   n_commit, n_drop            saturating result counters (only with RXB_STATS_EN)
// Build option: define RXB_STATS_EN to add the n_commit/n_drop counters.
module rx_bl_commit_buf
    import rxb_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = DEF_AW,
    parameter int unsigned DW    = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_ce,
    input  logic [DW-1:0] in_dat,
    input  logic [AW-1:0] in_adr,
    input  logic          blk_end,
    input  logic          blk_ok,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_dat,
    input  logic          mem_rdy,
    output logic          bl_commit,
    output logic          bl_drop,
`ifdef RXB_STATS_EN
    output logic [15:0]   n_commit,
    output logic [15:0]   n_drop,
`endif
    output logic          ovf
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IW    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    rxb_state_e       r_state, w_state_nx;
    logic [CNT_W-1:0] r_wr_cnt, w_wr_cnt_nx;
    logic [AW-1:0]    r_base, w_base_nx;
    logic             r_poison, w_poison_nx;
    logic             r_ovf, w_ovf_nx;
    logic [CNT_W-1:0] r_rd_idx, w_rd_idx_nx;   // next RAM index to read
    logic             r_s1_vld, w_s1_vld_nx;   // RAM output register holds a pending write
    logic [CNT_W-1:0] r_s1_idx, w_s1_idx_nx;   // block index of that pending write
    logic             r_commit, w_commit_nx;
    logic             r_drop, w_drop_nx;

    logic          w_ram_we, w_ram_re;
    logic [IW-1:0] w_ram_waddr, w_ram_raddr;
    logic [DW-1:0] w_rd_dat;
    logic          w_full, w_full_hit, w_adv, w_xfer;
    logic [7:0]    w_lo;

    rxb_sdp_ram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .IW    (IW)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (in_dat),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_rd_dat)
    );

    assign w_full     = (r_wr_cnt == FULL_CNT);
    assign w_full_hit = in_ce && w_full && (r_state == FILL);
    assign w_xfer     = r_s1_vld && mem_rdy;
    // The read pipeline may advance when its output slot is empty or being consumed this clock.
    assign w_adv      = !r_s1_vld || mem_rdy;

    always_comb begin
        w_state_nx  = r_state;
        w_wr_cnt_nx = r_wr_cnt;
        w_base_nx   = r_base;
        w_poison_nx = r_poison;
        w_ovf_nx    = r_ovf;
        w_rd_idx_nx = r_rd_idx;
        w_s1_vld_nx = r_s1_vld;
        w_s1_idx_nx = r_s1_idx;
        w_commit_nx = 1'b0;
        w_drop_nx   = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_waddr = r_wr_cnt[IW-1:0];
        w_ram_re    = 1'b0;
        w_ram_raddr = r_rd_idx[IW-1:0];

        unique case (r_state)
            IDLE: begin
                if (in_ce) begin
                    w_ram_we    = 1'b1;
                    w_ram_waddr = '0;
                    w_base_nx   = in_adr;
                end
                if (blk_end) begin
                    // A byte arriving with blk_end is a one-byte block.
                    if (in_ce && blk_ok && !r_poison) begin
                        w_state_nx  = DRAIN;
                        w_wr_cnt_nx = CNT_W'(1);
                        w_rd_idx_nx = '0;
                        w_s1_vld_nx = 1'b0;
                    end else if (!in_ce && blk_ok && !r_poison) begin
                        w_commit_nx = 1'b1;
                    end else begin
                        w_drop_nx   = 1'b1;
                        w_poison_nx = 1'b0;
                        w_wr_cnt_nx = '0;
                    end
                end else if (in_ce) begin
                    w_state_nx  = FILL;
                    w_wr_cnt_nx = CNT_W'(1);
                end
            end

            FILL: begin
                if (in_ce && !w_full) begin
                    w_ram_we    = 1'b1;
                    w_ram_waddr = r_wr_cnt[IW-1:0];
                    w_wr_cnt_nx = r_wr_cnt + 1'b1;
                end
                if (w_full_hit) begin
                    w_poison_nx = 1'b1;
                    w_ovf_nx    = 1'b1;
                end
                if (blk_end) begin
                    // A byte lost in this same clock also poisons the block.
                    if (blk_ok && !r_poison && !w_full_hit) begin
                        w_state_nx  = DRAIN;
                        w_rd_idx_nx = '0;
                        w_s1_vld_nx = 1'b0;
                    end else begin
                        w_state_nx  = IDLE;
                        w_drop_nx   = 1'b1;
                        w_wr_cnt_nx = '0;
                        w_poison_nx = 1'b0;
                    end
                end
            end

            DRAIN: begin
                // Bytes cannot be buffered while replaying; poison the following block instead.
                if (in_ce) begin
                    w_ovf_nx    = 1'b1;
                    w_poison_nx = 1'b1;
                end
                if (w_adv) begin
                    if (r_rd_idx < r_wr_cnt) begin
                        w_ram_re    = 1'b1;
                        w_s1_vld_nx = 1'b1;
                        w_s1_idx_nx = r_rd_idx;
                        w_rd_idx_nx = r_rd_idx + 1'b1;
                    end else begin
                        w_s1_vld_nx = 1'b0;
                    end
                end
                if (w_xfer && (r_s1_idx == r_wr_cnt - 1'b1)) begin
                    w_state_nx  = IDLE;
                    w_commit_nx = 1'b1;
                    w_wr_cnt_nx = '0;
                    w_rd_idx_nx = '0;
                    w_s1_vld_nx = 1'b0;
                end
            end

            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_wr_cnt <= '0;
            r_base   <= '0;
            r_poison <= 1'b0;
            r_ovf    <= 1'b0;
            r_rd_idx <= '0;
            r_s1_vld <= 1'b0;
            r_s1_idx <= '0;
            r_commit <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_wr_cnt <= w_wr_cnt_nx;
            r_base   <= w_base_nx;
            r_poison <= w_poison_nx;
            r_ovf    <= w_ovf_nx;
            r_rd_idx <= w_rd_idx_nx;
            r_s1_vld <= w_s1_vld_nx;
            r_s1_idx <= w_s1_idx_nx;
            r_commit <= w_commit_nx;
            r_drop   <= w_drop_nx;
        end
    end

    assign w_lo      = rxb_lo_add(r_base[7:0], 8'(r_s1_idx));
    assign mem_we    = r_s1_vld;
    assign mem_adr   = r_s1_vld ? {r_base[AW-1:8], w_lo} : '0;
    // The RAM read register is not reset; gating keeps the port quiet when idle.
    assign mem_dat   = r_s1_vld ? w_rd_dat : '0;
    assign bl_commit = r_commit;
    assign bl_drop   = r_drop;
    assign ovf       = r_ovf;

`ifdef RXB_STATS_EN
    logic [15:0] r_n_commit, r_n_drop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_n_commit <= '0;
            r_n_drop   <= '0;
        end else begin
            if (r_commit && (r_n_commit != 16'hFFFF)) begin
                r_n_commit <= r_n_commit + 16'd1;
            end
            if (r_drop && (r_n_drop != 16'hFFFF)) begin
                r_n_drop <= r_n_drop + 16'd1;
            end
        end
    end

    assign n_commit = r_n_commit;
    assign n_drop   = r_n_drop;
`endif

endmodule

// File: tb/tb_rx_bl_commit_buf.sv
// Testbench for rx_bl_commit_buf.
// The reference model works per block:
//   - It collects bytes in a queue.
//   - At block end it predicts the full write list, or a drop.
// A monitor pops the predictions as the DUT transfers words and pulses commit/drop.
module tb_rx_bl_commit_buf;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_ce;
    logic [7:0]  in_dat;
    logic [15:0] in_adr;
    logic        blk_end;
    logic        blk_ok;
    logic        mem_we;
    logic [15:0] mem_adr;
    logic [7:0]  mem_dat;
    logic        mem_rdy = 1'b0;
    logic        bl_commit;
    logic        bl_drop;
    logic        ovf;
`ifdef RXB_STATS_EN
    logic [15:0] n_commit;
    logic [15:0] n_drop;
`endif

    rx_bl_commit_buf u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_ce     (in_ce),
        .in_dat    (in_dat),
        .in_adr    (in_adr),
        .blk_end   (blk_end),
        .blk_ok    (blk_ok),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_dat   (mem_dat),
        .mem_rdy   (mem_rdy),
        .bl_commit (bl_commit),
        .bl_drop   (bl_drop),
`ifdef RXB_STATS_EN
        .n_commit  (n_commit),
        .n_drop    (n_drop),
`endif
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] adr;
        logic [7:0]  dat;
    } wr_t;

    typedef struct {
        bit drop;
        bit data;
        int ref_cyc;
    } ev_t;

    wr_t  exp_wr[$];
    ev_t  ev_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Block-level reference model state
    logic [7:0]  m_dat[$];
    logic [15:0] m_base;
    bit          m_poison = 0;
    bit          m_ovf = 0;
    bit          m_in_drain = 0;
    int          last_end_cyc = 0;

    // ready generator: 0 = always high, 1 = pattern 1,0,0, 2 = random
    int rdy_mode = 0;
    bit rdy_force = 0;
    int rdy_ph = 0;

    // monitor-owned observations
    int          xfer_cnt = 0;
    int          last_xfer_cyc = 0;
    int          last_rise_cyc = 0;
    logic [15:0] last_wr_adr = '0;
    bit          prev_stall = 0;
    bit          prev_we = 0;
    logic [15:0] prev_adr;
    logic [7:0]  prev_dat;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (rdy_force) begin
            mem_rdy = 1'b0;
        end else if (rdy_mode == 0) begin
            mem_rdy = 1'b1;
        end else if (rdy_mode == 1) begin
            mem_rdy = (rdy_ph % 3 == 0);
            rdy_ph++;
        end else begin
            mem_rdy = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
            prev_we = 0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!(mem_we === 1'b1 && mem_adr === prev_adr && mem_dat === prev_dat)) begin
                    errors++;
                    $display("FAIL stall_hold cyc %0d got we=%b adr=%h dat=%h want adr=%h dat=%h",
                             cyc, mem_we, mem_adr, mem_dat, prev_adr, prev_dat);
                end
            end
            if (mem_we && !prev_we) last_rise_cyc = cyc;
            if (mem_we === 1'b1 && mem_rdy === 1'b1) begin
                checks++;
                xfer_cnt++;
                last_xfer_cyc = cyc;
                last_wr_adr = mem_adr;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write cyc %0d got adr=%h dat=%h want none",
                             cyc, mem_adr, mem_dat);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    if (mem_adr !== w.adr || mem_dat !== w.dat) begin
                        errors++;
                        $display("FAIL write cyc %0d got adr=%h dat=%h want adr=%h dat=%h",
                                 cyc, mem_adr, mem_dat, w.adr, w.dat);
                    end
                end
            end
            if (bl_commit === 1'b1 || bl_drop === 1'b1) begin
                checks++;
                if (ev_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc %0d got commit=%b drop=%b want none",
                             cyc, bl_commit, bl_drop);
                end else begin
                    ev_t e;
                    int  want_cyc;
                    e = ev_q.pop_front();
                    want_cyc = e.data ? last_xfer_cyc + 1 : e.ref_cyc + 1;
                    if (bl_commit !== !e.drop || bl_drop !== e.drop || cyc != want_cyc
                        || (e.data && exp_wr.size() != 0)) begin
                        errors++;
                        $display("FAIL result cyc %0d got commit=%b drop=%b left=%0d want %s at %0d",
                                 cyc, bl_commit, bl_drop, exp_wr.size(),
                                 e.drop ? "drop" : "commit", want_cyc);
                    end
                end
            end
            prev_stall = mem_we && !mem_rdy;
            prev_we = mem_we;
            prev_adr = mem_adr;
            prev_dat = mem_dat;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic void model_add(input logic [15:0] adr, input logic [7:0] dat);
        if (m_in_drain || m_dat.size() == DEPTH) begin
            m_poison = 1;
            m_ovf = 1;
        end else begin
            if (m_dat.size() == 0) m_base = adr;
            m_dat.push_back(dat);
        end
    endfunction

    function automatic void model_end(input bit ok);
        ev_t e;
        e.ref_cyc = cyc;
        e.drop = !ok || m_poison;
        e.data = 0;
        if (!e.drop && m_dat.size() > 0) begin
            e.data = 1;
            for (int i = 0; i < m_dat.size(); i++) begin
                wr_t  w;
                logic [7:0] lo;
                lo = m_base[7:0] + 8'(i);
                w.adr = {m_base[15:8], lo};
                w.dat = m_dat[i];
                exp_wr.push_back(w);
            end
        end
        ev_q.push_back(e);
        m_dat.delete();
        m_poison = 0;
    endfunction

    // All drive tasks start and end #1 after a rising edge.
    task automatic drive_byte(input logic [15:0] adr, input logic [7:0] dat);
        in_ce = 1'b1;
        in_adr = adr;
        in_dat = dat;
        model_add(adr, dat);
        @(posedge clk);
        #1;
        in_ce = 1'b0;
    endtask

    task automatic end_block(input bit ok, input bit with_byte, input logic [15:0] adr,
                             input logic [7:0] dat);
        in_ce = with_byte;
        in_adr = adr;
        in_dat = dat;
        blk_end = 1'b1;
        blk_ok = ok;
        if (with_byte) model_add(adr, dat);
        last_end_cyc = cyc;
        model_end(ok);
        @(posedge clk);
        #1;
        in_ce = 1'b0;
        blk_end = 1'b0;
        blk_ok = 1'b0;
    endtask

    task automatic send_block(input logic [15:0] base, input int n, input bit ok, input bit gaps,
                              input bit merge_end, input bit rnd_dat);
        for (int i = 0; i < n; i++) begin
            logic [7:0] lo;
            logic [7:0] d;
            lo = base[7:0] + 8'(i);
            d = rnd_dat ? 8'($urandom) : 8'hA0 + 8'(i);
            if (merge_end && i == n - 1) begin
                end_block(ok, 1, {base[15:8], lo}, d);
            end else begin
                drive_byte({base[15:8], lo}, d);
                if (gaps) repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        if (!(merge_end && n > 0)) end_block(ok, 0, '0, '0);
    endtask

    task automatic flush_model();
        exp_wr.delete();
        ev_q.delete();
        m_dat.delete();
        m_poison = 0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((exp_wr.size() != 0 || ev_q.size() != 0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s timeout got %0d writes %0d results pending want 0",
                     nm, exp_wr.size(), ev_q.size());
            flush_model();
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        int n;
        rst_n = 1'b0;
        in_ce = 1'b0;
        in_dat = '0;
        in_adr = '0;
        blk_end = 1'b0;
        blk_ok = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_adr", 32'(mem_adr), 0);
        chk("rst_mem_dat", 32'(mem_dat), 0);
        chk("rst_commit", 32'(bl_commit), 0);
        chk("rst_drop", 32'(bl_drop), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // good block, latency and count
        x0 = xfer_cnt;
        send_block(16'h0100, 4, 1, 0, 0, 0);
        wait_idle("t1");
        chk("t1_latency", 32'(last_rise_cyc), 32'(last_end_cyc + 2));
        chk("t1_count", 32'(xfer_cnt - x0), 4);

        // bad CRC then good block
        x0 = xfer_cnt;
        send_block(16'h0200, 3, 0, 0, 0, 1);
        wait_idle("t2_bad");
        chk("t2_bad_count", 32'(xfer_cnt - x0), 0);
        send_block(16'h0300, 2, 1, 0, 0, 1);
        wait_idle("t2_good");

        // backpressure
        rdy_mode = 1;
        x0 = xfer_cnt;
        send_block(16'h0400, 5, 1, 0, 0, 1);
        wait_idle("t3");
        chk("t3_count", 32'(xfer_cnt - x0), 5);
        rdy_mode = 0;

        // low-byte wrap
        send_block(16'h12FE, 4, 1, 0, 0, 1);
        wait_idle("t4");
        chk("t4_last_adr", 32'(last_wr_adr), 32'h1201);

        // empty blocks and byte merged with blk_end
        end_block(1, 0, '0, '0);
        wait_idle("empty_ok");
        end_block(0, 0, '0, '0);
        wait_idle("empty_bad");
        send_block(16'h0500, 3, 1, 0, 1, 1);
        wait_idle("merged");
        send_block(16'h0600, 1, 1, 0, 1, 1);
        wait_idle("merged_one");

        // random blocks
        rdy_mode = 2;
        for (int b = 0; b < 12; b++) begin
            send_block(16'($urandom), $urandom_range(0, 24), $urandom_range(0, 3) != 0,
                       1, $urandom_range(0, 1) == 1, 1);
            wait_idle("random");
        end
        rdy_mode = 0;
        chk("no_ovf_yet", 32'(ovf), 32'(m_ovf));

        // byte arriving during DRAIN
        x0 = xfer_cnt;
        send_block(16'h0700, 6, 1, 0, 0, 1);
        m_in_drain = 1;
        drive_byte(16'h0800, 8'h55);
        m_in_drain = 0;
        wait_idle("t5_drain");
        chk("t5_drain_count", 32'(xfer_cnt - x0), 6);
        chk("t5_drain_ovf", 32'(ovf), 1);
        x0 = xfer_cnt;
        send_block(16'h0900, 3, 1, 0, 0, 1);
        wait_idle("t5_next");
        chk("t5_next_count", 32'(xfer_cnt - x0), 0);

        // overflow: DEPTH+1 bytes
        x0 = xfer_cnt;
        send_block(16'h0A00, DEPTH + 1, 1, 0, 0, 1);
        wait_idle("t5_ovf");
        chk("t5_ovf_count", 32'(xfer_cnt - x0), 0);
        chk("t5_ovf_flag", 32'(ovf), 32'(m_ovf));

        // reset in the middle of a drain
        x0 = xfer_cnt;
        send_block(16'h0B00, 8, 1, 0, 0, 1);
        n = 0;
        while (xfer_cnt < x0 + 3 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_started", 32'(xfer_cnt >= x0 + 3), 1);
        rst_n = 1'b0;
        rdy_force = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        flush_model();
        m_ovf = 0;
        chk("t6_we_low", 32'(mem_we), 0);
        chk("t6_ovf_clr", 32'(ovf), 0);
        rdy_force = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        x0 = xfer_cnt;
        send_block(16'h0C10, 3, 1, 0, 0, 1);
        wait_idle("t6_after");
        chk("t6_after_count", 32'(xfer_cnt - x0), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
